// File: rtl/alu_pipe.sv
// alu_pipe: registered MIPS-style ALU with valid/ready handshakes.
//   Single-cycle ops (logic, add/sub, compares, shifts) return one cycle
//   after accept; MUL runs an iterative shift-add over WIDTH cycles.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid / in_ready   operand handshake (a, b, op)
//   out_valid / out_ready result handshake (res + flags)
//   res                   result
//   zero, neg             res == 0, res MSB
//   carry, ovf            ADD/SUB carry (NOT borrow) and signed overflow
//   illegal               op not decoded, res forced to 0
//   busy                  multiplier iterating
//
// state  | meaning
// S_IDLE | accepting ops, single-cycle results written on accept edge
// S_MUL  | shift-add multiply in progress, input stalled
module alu_pipe #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             zero,
  output logic             neg,
  output logic             carry,
  output logic             ovf,
  output logic             illegal,
  output logic             busy
);

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_mcand, r_mplier, r_acc;
  logic [SHW-1:0]   r_cnt;

  logic [WIDTH:0]   w_sum, w_diff;
  logic [SHW-1:0]   w_shamt;
  logic [WIDTH-1:0] w_res, w_mul_res;
  logic             w_carry, w_ovf, w_illegal, w_is_mul;
  logic             w_ovf_add, w_ovf_sub, w_accept;

  assign in_ready = !rst && (r_state == S_IDLE) && (!out_valid || out_ready);
  assign w_accept = in_valid && in_ready;
  assign w_shamt  = b[SHW-1:0];

  // Subtraction as a + ~b + 1 so the top bit is directly NOT borrow.
  assign w_sum  = {1'b0, a} + {1'b0, b};
  assign w_diff = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};

  assign w_ovf_add = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1]  != a[WIDTH-1]);
  assign w_ovf_sub = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);

  // Last multiply step folds in the final partial product directly.
  assign w_mul_res = r_acc + (r_mplier[0] ? r_mcand : '0);

  always_comb begin
    w_res     = '0;
    w_carry   = 1'b0;
    w_ovf     = 1'b0;
    w_illegal = 1'b0;
    w_is_mul  = 1'b0;
    case (op)
      4'b0000: w_res = a & b;
      4'b0001: w_res = a | b;
      4'b0010: begin
        w_res   = w_sum[WIDTH-1:0];
        w_carry = w_sum[WIDTH];
        w_ovf   = w_ovf_add;
      end
      4'b0110: begin
        w_res   = w_diff[WIDTH-1:0];
        w_carry = w_diff[WIDTH];
        w_ovf   = w_ovf_sub;
      end
      // Signed less-than must correct the difference sign for overflow.
      4'b0111: w_res = {{(WIDTH-1){1'b0}}, w_diff[WIDTH-1] ^ w_ovf_sub};
      4'b1001: w_res = {{(WIDTH-1){1'b0}}, !w_diff[WIDTH]};
      4'b1100: w_res = ~(a | b);
      4'b0011: w_res = a << w_shamt;
      4'b0100: w_res = a >> w_shamt;
      4'b0101: w_res = $signed(a) >>> w_shamt;
      4'b1000: w_is_mul = 1'b1;
      default: w_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      out_valid <= 1'b0;
      res       <= '0;
      zero      <= 1'b0;
      neg       <= 1'b0;
      carry     <= 1'b0;
      ovf       <= 1'b0;
      illegal   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_is_mul) begin
              r_state  <= S_MUL;
              r_mcand  <= a;
              r_mplier <= b;
              r_acc    <= '0;
              r_cnt    <= '0;
              busy     <= 1'b1;
            end else begin
              res       <= w_res;
              zero      <= (w_res == '0);
              neg       <= w_res[WIDTH-1];
              carry     <= w_carry;
              ovf       <= w_ovf;
              illegal   <= w_illegal;
              out_valid <= 1'b1;
            end
          end
        end
        S_MUL: begin
          r_acc    <= w_mul_res;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 1'b1;
          if (r_cnt == SHW'(WIDTH-1)) begin
            res       <= w_mul_res;
            zero      <= (w_mul_res == '0);
            neg       <= w_mul_res[WIDTH-1];
            carry     <= 1'b0;
            ovf       <= 1'b0;
            illegal   <= 1'b0;
            out_valid <= 1'b1;
            busy      <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, registered MIPS-style ALU for the single-cycle/multicycle datapath.
- Adds width parameter, full flag set (zero/negative/carry/overflow), shifts, unsigned compare and an iterative shift-add multiplier.
- Uses valid/ready handshakes on input and output so that multicycle ops can stall the issuing stage.
- Sits between the register-read/operand-mux stage and writeback/branch logic.

Parameters:
- WIDTH, 32, operand/result width in bits (≥ 4, power of two).
- SHW, $clog2(WIDTH), shift-amount width taken from b[SHW-1:0].

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  operands/op present.
- in_ready  out  1  block accepts operation this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B / shift amount.
- op  in  4  operation code.
- out_valid  out  1  result/flags valid.
- out_ready  in  1  consumer takes result this cycle.
- res  out  WIDTH  result.
- zero  out  1  res == 0.
- neg  out  1  res[WIDTH-1].
- carry  out  1  carry out (ADD) / NOT borrow (SUB), else 0.
- ovf  out  1  signed overflow (ADD/SUB), else 0.
- illegal  out  1  op not in table (res = 0).
- busy  out  1  multiplier iterating.

Behaviour:
- Reset: all outputs 0, state IDLE, multiplier regs 0. in_ready is 0 during rst. Reset mid-multiply aborts the operation; no result is produced.
- Op table:
  - 0000 AND; 0001 OR; 0010 ADD; 0110 SUB; 0111 SLT (signed); 1001 SLTU; 1100 NOR.
  - 0011 SLL; 0100 SRL; 0101 SRA (amount b[SHW-1:0]).
  - 1000 MUL (low WIDTH bits of a*b).
  - Any other op: illegal = 1, res = 0.
- SLT/SLTU: res = {0…,lt}. SLT lt is computed from sign-correct compare (a-b sign XOR overflow), not raw temp MSB.
- Flags are computed from the final res every op. zero and neg are always valid. carry and ovf are nonzero only for ADD/SUB.
- Accept: transfer occurs when in_valid && in_ready.
- in_ready = (state == IDLE) && (!out_valid || out_ready).
- Single-cycle ops: result/flags registered on the accept edge; out_valid = 1 the next cycle (latency 1). Back-to-back throughput is 1/cycle while out_ready = 1.
- MUL FSM:
  - IDLE→MUL on accept: latch mcand = a, mplier = b, acc = 0, cnt = 0, busy = 1.
  - Each MUL cycle: if mplier[0], acc += mcand; mcand <<= 1; mplier >>= 1; cnt++.
  - After WIDTH iterations (cnt == WIDTH-1 step): load res = acc (+ final add), set flags, out_valid = 1, busy = 0, →IDLE.
  - Latency is exactly WIDTH+1 cycles from accept to out_valid.
- Output hold: out_valid, res and flags hold stable until out_valid && out_ready. out_valid clears on that edge unless a new op is accepted in the same cycle, in which case it is replaced.
- in_valid while busy or stalled is ignored; the operands are not sampled.
- Arithmetic is modulo 2^WIDTH. Shift amounts ≥ WIDTH cannot occur, since they are truncated to SHW bits.

Test Plan:
- Reset: assert rst 2 cycles mid-stream → all outputs 0, in_ready = 0; after release in_ready = 1 next cycle.
- ADD overflow: WIDTH=32, a=0x7FFFFFFF, b=1, op 0010 → one cycle later res=0x80000000, ovf=1, neg=1, carry=0, zero=0.
- SUB equal / SLT signed: a=b=5, SUB → res=0, zero=1, carry=1. a=0xFFFFFFFF, b=1, SLT → res=1; same operands SLTU → res=0.
- Shifts: a=0x80000000, b=4: SRA → 0xF8000000; SRL → 0x08000000; SLL → 0x00000000 with zero=1.
- MUL with stall: a=123, b=456 → busy for 32 cycles, in_ready=0 throughout; res=56088 at cycle 33. A new in_valid during busy is ignored. a=0xFFFFFFFF, b=2 → res=0xFFFFFFFE.
- Backpressure/illegal: hold out_ready=0 after an AND result → res held and in_ready=0; release → next op accepted the same cycle; op 1111 → illegal=1, res=0.
